usr_shift_sequencer: RTL and testbench

Command-driven sequencer for the 4-bit universal shift register. It accepts load, shift and rotate commands over a valid/ready interface and drives the register's `select`, `p_din` and serial inputs cycle by cycle. It feeds the register output back into `p_din`, because the register shifts `p_din`, not its own contents. When the command completes, it returns the resulting word over a response handshake. The sequencer sits between the register and any client logic, and it is the only driver of the register's control inputs.

---
 rtl/usr_shift_sequencer.sv | 148 ++++++++++++++
 tb/tb_usr_shift_sequencer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usr_shift_sequencer.sv
// Command sequencer for the 4-bit universal shift register: loads, shifts or
// rotates the register step by step and returns the resulting word.
module usr_shift_sequencer #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic             cmd_rotate,
  input  logic             cmd_fill,
  input  logic             cmd_keep,
  input  logic [3:0]       cmd_data,
  input  logic [CNT_W-1:0] cmd_count,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [3:0]       rsp_data,
  output logic             busy,
  output logic [1:0]       usr_select,
  output logic [3:0]       usr_p_din,
  output logic             usr_s_left_din,
  output logic             usr_s_right_din,
  input  logic [3:0]       usr_p_dout
);

  localparam int unsigned DW = 4;

  localparam logic [1:0] SEL_HOLD  = 2'b00;
  localparam logic [1:0] SEL_RIGHT = 2'b01;
  localparam logic [1:0] SEL_LEFT  = 2'b10;
  localparam logic [1:0] SEL_LOAD  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic             rot_q, rot_d;
  logic             fill_q, fill_d;
  logic [DW-1:0]    data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic cmd_is_shift_c;
  logic lat_is_shift_c;

  assign cmd_is_shift_c = (cmd_op == SEL_RIGHT) || (cmd_op == SEL_LEFT);
  assign lat_is_shift_c = (op_q == SEL_RIGHT) || (op_q == SEL_LEFT);

  // The result is whatever the register currently holds; stable in DONE since select is hold.
  assign rsp_data = usr_p_dout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= 2'b00;
      rot_q   <= 1'b0;
      fill_q  <= 1'b0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rot_q   <= rot_d;
      fill_q  <= fill_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    op_d            = op_q;
    rot_d           = rot_q;
    fill_d          = fill_q;
    data_d          = data_q;
    cnt_d           = cnt_q;
    cmd_ready       = 1'b0;
    rsp_valid       = 1'b0;
    busy            = 1'b1;
    usr_select      = SEL_HOLD;
    usr_p_din       = '0;
    usr_s_left_din  = 1'b0;
    usr_s_right_din = 1'b0;

    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) begin
          op_d   = cmd_op;
          rot_d  = cmd_rotate;
          fill_d = cmd_fill;
          data_d = cmd_data;
          cnt_d  = cmd_count;
          if (!cmd_keep) begin
            state_d = S_LOAD;
          end else if ((cmd_count != '0) && cmd_is_shift_c) begin
            state_d = S_SHIFT;
          end else begin
            state_d = S_DONE;
          end
        end
      end

      S_LOAD: begin
        usr_select = SEL_LOAD;
        usr_p_din  = data_q;
        if ((cnt_q != '0) && lat_is_shift_c) begin
          state_d = S_SHIFT;
        end else begin
          state_d = S_DONE;
        end
      end

      // The register shifts p_din, so its own output is fed back each step.
      S_SHIFT: begin
        usr_select = op_q;
        usr_p_din  = usr_p_dout;
        if (op_q == SEL_RIGHT) begin
          usr_s_right_din = rot_q ? usr_p_dout[0] : fill_q;
        end else if (op_q == SEL_LEFT) begin
          usr_s_left_din = rot_q ? usr_p_dout[DW-1] : fill_q;
        end
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_usr_shift_sequencer.sv
// Bench for usr_shift_sequencer: behavioural 4-bit register attached to the
// sequencer, expected words and latencies scoreboarded per command.
module tb_usr_shift_sequencer;

  localparam int unsigned CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic             cmd_rotate;
  logic             cmd_fill;
  logic             cmd_keep;
  logic [3:0]       cmd_data;
  logic [CNT_W-1:0] cmd_count;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [3:0]       rsp_data;
  logic             busy;
  logic [1:0]       usr_select;
  logic [3:0]       usr_p_din;
  logic             usr_s_left_din;
  logic             usr_s_right_din;
  logic [3:0]       usr_p_dout;

  usr_shift_sequencer #(.CNT_W(CNT_W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_op          (cmd_op),
    .cmd_rotate      (cmd_rotate),
    .cmd_fill        (cmd_fill),
    .cmd_keep        (cmd_keep),
    .cmd_data        (cmd_data),
    .cmd_count       (cmd_count),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_data        (rsp_data),
    .busy            (busy),
    .usr_select      (usr_select),
    .usr_p_din       (usr_p_din),
    .usr_s_left_din  (usr_s_left_din),
    .usr_s_right_din (usr_s_right_din),
    .usr_p_dout      (usr_p_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Universal shift register the sequencer drives
  logic [3:0] reg_q;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) reg_q <= 4'b0000;
    else begin
      case (usr_select)
        2'b01:   reg_q <= {usr_s_right_din, usr_p_din[3:1]};
        2'b10:   reg_q <= {usr_p_din[2:0], usr_s_left_din};
        2'b11:   reg_q <= usr_p_din;
        default: reg_q <= reg_q;
      endcase
    end
  end
  assign usr_p_dout = reg_q;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    logic [3:0] data;
    int         lat;
    int         e0;
  } sb_t;

  sb_t        sb_q[$];
  logic [3:0] exp_reg = 4'b0000;
  int         last_e0 = 0;
  int         last_hs_cyc = 0;
  int         rise_cyc = 0;
  logic       prev_valid = 1'b0;
  logic       sel11_seen = 1'b0;

  function automatic logic [3:0] calc(input logic [3:0] cur, input logic [1:0] op,
                                      input logic rot, input logic fill, input logic keep,
                                      input logic [3:0] data, input int cnt);
    logic [3:0] r;
    r = keep ? cur : data;
    if (op == 2'b01 || op == 2'b10) begin
      for (int i = 0; i < cnt; i++) begin
        if (op == 2'b01) r = {(rot ? r[0] : fill), r[3:1]};
        else             r = {r[2:0], (rot ? r[3] : fill)};
      end
    end
    return r;
  endfunction

  function automatic int calc_lat(input logic [1:0] op, input logic keep, input int cnt);
    int steps;
    steps = ((op == 2'b01 || op == 2'b10) && cnt > 0) ? cnt : 0;
    return keep ? steps : steps + 1;
  endfunction

  // Response monitor: latency from acceptance to rsp_valid rise, data at handshake
  always @(negedge clk) begin
    if (usr_select == 2'b11) sel11_seen = 1'b1;
    if (rsp_valid && !prev_valid) rise_cyc = cyc;
    prev_valid = rsp_valid;
    if (rsp_valid && rsp_ready) begin
      if (sb_q.size() == 0) begin
        check_eq("rsp_unexpected", 32'(sb_q.size()), 32'd1);
      end else begin
        sb_t e;
        e = sb_q.pop_front();
        check_eq("rsp_data", 32'(rsp_data), 32'(e.data));
        check_eq("rsp_latency", 32'(rise_cyc - e.e0), 32'(e.lat));
      end
      last_hs_cyc = cyc;
    end
  end

  task automatic send(input logic [1:0] op, input logic rot, input logic fill,
                      input logic keep, input logic [3:0] data, input int cnt);
    int   n;
    logic rdy;
    sb_t  e;
    @(negedge clk);
    cmd_op     = op;
    cmd_rotate = rot;
    cmd_fill   = fill;
    cmd_keep   = keep;
    cmd_data   = data;
    cmd_count  = CNT_W'(cnt);
    cmd_valid  = 1'b1;
    n = 0;
    forever begin
      rdy = cmd_ready;
      @(posedge clk);
      #1;
      if (rdy) break;
      n++;
      if (n > 200) begin
        check_eq("accept_timeout", 32'(n), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "command never accepted");
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    exp_reg   = calc(exp_reg, op, rot, fill, keep, data, cnt);
    e.data    = exp_reg;
    e.lat     = calc_lat(op, keep, cnt);
    e.e0      = cyc;
    last_e0   = cyc;
    sb_q.push_back(e);
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!rsp_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    check_eq("wait_valid", 32'(rsp_valid), 32'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    rst_n      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_op     = 2'b00;
    cmd_rotate = 1'b0;
    cmd_fill   = 1'b0;
    cmd_keep   = 1'b0;
    cmd_data   = 4'b0000;
    cmd_count  = '0;
    rsp_ready  = 1'b1;

    #12;
    check_eq("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_select", 32'(usr_select), 32'd0);
    check_eq("rst_p_din", 32'(usr_p_din), 32'd0);
    check_eq("rst_serial", 32'({usr_s_left_din, usr_s_right_din}), 32'd0);
    check_eq("rst_rsp_data", 32'(rsp_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    send(2'b01, 1'b0, 1'b0, 1'b0, 4'b1011, 1);
    send(2'b01, 1'b1, 1'b0, 1'b0, 4'b1011, 1);
    send(2'b10, 1'b1, 1'b0, 1'b0, 4'b1001, 2);
    send(2'b10, 1'b0, 1'b1, 1'b0, 4'b0000, 6);
    send(2'b00, 1'b0, 1'b0, 1'b0, 4'b1010, 0);
    drain();

    // Keep with no shift: response right after acceptance, never a parallel load
    sel11_seen = 1'b0;
    send(2'b00, 1'b0, 1'b0, 1'b1, 4'b0101, 0);
    drain();
    check_eq("keep_no_load", 32'(sel11_seen), 32'd0);
    send(2'b11, 1'b1, 1'b1, 1'b1, 4'b0000, 3);
    send(2'b01, 1'b1, 1'b0, 1'b1, 4'b0000, 3);
    send(2'b11, 1'b0, 1'b0, 1'b0, 4'b0110, 5);
    drain();

    // Response back-pressure with a command queued behind it
    rsp_ready = 1'b0;
    send(2'b00, 1'b0, 1'b0, 1'b0, 4'b0101, 0);
    fork
      send(2'b10, 1'b1, 1'b0, 1'b1, 4'b0000, 1);
      begin
        wait_valid();
        for (int i = 0; i < 3; i++) begin
          check_eq("hold_rsp_data", 32'(rsp_data), 32'h5);
          check_eq("hold_cmd_ready", 32'(cmd_ready), 32'd0);
          check_eq("hold_select", 32'(usr_select), 32'd0);
          @(negedge clk);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
      end
    join
    check_eq("b2b_accept_edge", 32'(last_e0), 32'(last_hs_cyc + 2));
    drain();

    // Randomised commands
    for (int i = 0; i < 16; i++) begin
      send(2'($urandom_range(3)), 1'($urandom_range(1)), 1'($urandom_range(1)),
           1'($urandom_range(1)), 4'($urandom_range(15)), int'($urandom_range(15)));
    end
    drain();

    // Reset in the middle of a shifting command
    send(2'b10, 1'b0, 1'b1, 1'b0, 4'b0000, 10);
    repeat (5) @(posedge clk);
    #1;
    check_eq("mid_shift_reg", 32'(reg_q), 32'hF);
    rst_n = 1'b0;
    #1;
    check_eq("arst_busy", 32'(busy), 32'd0);
    check_eq("arst_select", 32'(usr_select), 32'd0);
    check_eq("arst_reg", 32'(reg_q), 32'd0);
    check_eq("arst_rsp_valid", 32'(rsp_valid), 32'd0);
    sb_q.delete();
    exp_reg = 4'b0000;
    repeat (3) begin
      @(negedge clk);
      check_eq("arst_no_rsp", 32'(rsp_valid), 32'd0);
    end
    rst_n = 1'b1;
    send(2'b01, 1'b1, 1'b0, 1'b0, 4'b0011, 2);
    drain();

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
